// File: rtl/reg_file_rw.sv
// reg_file_rw: 2**DEPTH_LOG2 x WIDTH register file with hardwired x0,
// two operand reads, a link (x31) read, a debug read and write tracking.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   we, wr_index, wr_data
//                        write-back port; commits on the rising edge
//   rd_index1/rd_data1   operand A read (combinational, optional bypass)
//   rd_index2/rd_data2   operand B read (combinational, optional bypass)
//   ra_data              register 31 read (same bypass rule)
//   dbg_index/dbg_data   stored-value debug read, never bypassed
//   last_wr_index/last_wr_data
//                        most recent committed write
//   wr_count             committed writes since reset, wraps
module reg_file_rw #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int BYPASS     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_index,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_index1,
    input  logic [DEPTH_LOG2-1:0] rd_index2,
    output logic [WIDTH-1:0]      rd_data1,
    output logic [WIDTH-1:0]      rd_data2,
    output logic [WIDTH-1:0]      ra_data,
    input  logic [DEPTH_LOG2-1:0] dbg_index,
    output logic [WIDTH-1:0]      dbg_data,
    output logic [DEPTH_LOG2-1:0] last_wr_index,
    output logic [WIDTH-1:0]      last_wr_data,
    output logic [CNT_W-1:0]      wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] RA_IDX = DEPTH_LOG2'(31);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             commit;

    // Writes to x0 are dropped entirely: no store, no tracking update.
    assign commit = we && (wr_index != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            last_wr_index <= '0;
            last_wr_data  <= '0;
            wr_count      <= '0;
        end else if (commit) begin
            regs[wr_index] <= wr_data;
            last_wr_index  <= wr_index;
            last_wr_data   <= wr_data;
            wr_count       <= wr_count + CNT_W'(1);
        end
    end

    // Forward this cycle's write data when the read hits the write target.
    // commit already excludes x0, so x0 reads always come from storage (0).
    function automatic logic [WIDTH-1:0] rd_port(
        input logic [DEPTH_LOG2-1:0] idx,
        input logic [WIDTH-1:0]      stored
    );
        if ((BYPASS != 0) && commit && (idx == wr_index)) begin
            return wr_data;
        end
        return stored;
    endfunction

    assign rd_data1 = rd_port(rd_index1, regs[rd_index1]);
    assign rd_data2 = rd_port(rd_index2, regs[rd_index2]);
    assign ra_data  = rd_port(RA_IDX, regs[RA_IDX]);
    assign dbg_data = regs[dbg_index];

endmodule

// File: doc/reg_file_rw.md
Name: reg_file_rw

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle CPU.
- Sink for the write-back selector's (reg_index, reg_data) pair, which carries either the ALU/memory result or the link address PC+4 into register 31.
- Serves the two combinational operand reads for the decode/execute stage, a link-register read for JR, and a debug read port.
- Commits writes on the clock edge and tracks write activity for trace/debug.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH_LOG2, 5, index width; the file holds 2**DEPTH_LOG2 registers.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data; 0 = it returns the stored value.
- CNT_W, 16, width of the write commit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable for this cycle.
- wr_index  input  DEPTH_LOG2  destination register from the write-back selector.
- wr_data  input  WIDTH  write data from the write-back selector (result or PC+4).
- rd_index1  input  DEPTH_LOG2  operand A register index.
- rd_index2  input  DEPTH_LOG2  operand B register index.
- rd_data1  output  WIDTH  operand A value, combinational.
- rd_data2  output  WIDTH  operand B value, combinational.
- ra_data  output  WIDTH  current value of register 31, combinational, with the same bypass rule.
- dbg_index  input  DEPTH_LOG2  debug read index.
- dbg_data  output  WIDTH  stored value at dbg_index; never bypassed.
- last_wr_index  output  DEPTH_LOG2  index of the most recent committed write.
- last_wr_data  output  WIDTH  data of the most recent committed write.
- wr_count  output  CNT_W  number of committed writes since reset.

Behaviour:
- Reset:
  - Asynchronous; rst_n low clears all registers to 0 immediately, regardless of clk.
  - last_wr_index=0, last_wr_data=0, wr_count=0.
  - While rst_n is low, writes are ignored.
  - A write edge coincident with reset assertion is lost.
  - Release is synchronous to nothing; the first rising edge with rst_n high may commit.
- Write:
  - On the rising clk edge with we=1 and wr_index!=0, reg[wr_index] <= wr_data.
  - Single-cycle latency: the value is visible from stored reads in the cycle after the edge.
- Register 0:
  - Hardwired zero.
  - A write with wr_index=0 leaves reg[0] at 0, does not update last_wr_* and does not increment wr_count.
  - Reads of index 0 always return 0, including under bypass.
- Commit tracking:
  - On each committed write, last_wr_index <= wr_index, last_wr_data <= wr_data, wr_count <= wr_count+1.
  - wr_count wraps modulo 2**CNT_W (0xFFFF -> 0x0000) with no saturation.
- Reads:
  - rd_data1, rd_data2 and ra_data are combinational from the array.
  - If BYPASS=1, we=1, wr_index!=0 and the read index equals wr_index, the port returns wr_data in the same cycle.
  - ra_data uses index 31 for this comparison.
  - If BYPASS=0, every read returns the stored value.
- Simultaneous events:
  - Both read ports and ra_data may address the same register as the write; each resolves independently by the bypass rule.
  - The write-back selector's link write (index 31, PC+4) updates ra_data on the next edge, or the same cycle under bypass.
- No X on outputs after reset for any in-range index; all indices are in range by construction.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing reg5=0xDEADBEEF -> rd_data1 (rd_index1=5) reads 0 immediately, wr_count=0, last_wr_index=0.
- Write/read: we=1, wr_index=7, wr_data=0x12345678, edge -> next cycle rd_data2 (rd_index2=7)=0x12345678, last_wr_index=7, last_wr_data=0x12345678, wr_count=1.
- x0: we=1, wr_index=0, wr_data=0xFFFFFFFF, edge -> rd_data1 (rd_index1=0)=0, wr_count unchanged, last_wr_* unchanged.
- Link/bypass:
  - BYPASS=1, we=1, wr_index=31, wr_data=0x00400010 (PC+4), rd_index1=31 -> rd_data1 and ra_data=0x00400010 before the edge; dbg_data (dbg_index=31) still shows the old value until the edge.
  - BYPASS=0: same stimulus -> old value before the edge, 0x00400010 after.
- Counter wrap: preload via 65535 committed writes -> wr_count=0xFFFF; one more write to reg3 -> wr_count=0x0000, reg3 updated.
- Back-to-back: writes to reg9 of 0x1, 0x2, 0x3 on consecutive edges while rd_index1=rd_index2=9, BYPASS=1 -> both ports track 0x1, 0x2, 0x3 in the cycle each is presented; final stored value 0x3.
